cpu_run_monitor: RTL and testbench
==================================

// Module: cpu_run_monitor
// PURPOSE
//   Synthesizable run controller and checker that sits beside the CPU top.
//   Sequences the core's reset, counts run cycles, and watches the core result
//   bus (rd). Declares PASS when rd holds an expected value for N consecutive
//   cycles; declares FAIL (timeout) after MAX_CYCLES. Replaces fixed-delay
//   bench runs with a self-checking verdict usable in simulation and on FPGA.
// PARAMETERS
//   WIDTH         32            width of the monitored rd bus
//   RST_CYCLES    2             cycles core reset is held low after iRstN release (>=1)
//   MAX_CYCLES    100           RUN-cycle budget before FAIL (>=1)
//   STABLE_CYCLES 4             consecutive cycles rd==EXPECT needed for PASS (>=1)
//   EXPECT        32'h0000_000A expected final rd value (WIDTH bits)
//   HALT_ON_DONE  0             1: drive core reset low again once PASS/FAIL is reached
//   CNT_W         16            width of the cycle and change counters
// PORTS
//   iClk        in   1      clock, all logic on rising edge
//   iRstN       in   1      synchronous active-low reset
//   iRd         in   WIDTH  core result bus, sampled every cycle
//   iRestart    in   1      1-cycle pulse; restarts the run from a terminal state only
//   oCoreRstN   out  1      active-low reset to the CPU top (registered)
//   oDone       out  1      1 in PASS or FAIL
//   oPass       out  1      1 in PASS
//   oFail       out  1      1 in FAIL (timeout)
//   oCycles     out  CNT_W  RUN cycles elapsed, saturating at all-ones
//   oRdChanges  out  CNT_W  count of cycles where iRd differs from previous sample, saturating
// BEHAVIOUR
//   Reset (iRstN==0 at an edge): state=HOLD, hold/stable counters=0, prev_rd=0,
//     oCoreRstN=0, oDone=oPass=oFail=0, oCycles=0, oRdChanges=0. Wins over all else.
//   States: HOLD -> RUN -> {PASS | FAIL}. PASS/FAIL are terminal until iRestart.
//   HOLD: hold_cnt++ each edge. At the edge where hold_cnt==RST_CYCLES-1: go RUN
//     and set oCoreRstN=1. The core sees reset low for exactly RST_CYCLES cycles.
//   RUN, at each edge:
//     - oCycles++ (saturating).
//     - prev_rd<=iRd. oRdChanges++ if iRd!=prev_rd, except on the first RUN edge,
//       where the compare is suppressed.
//     - If iRd==EXPECT: stable_cnt++; else stable_cnt=0.
//     - PASS when iRd==EXPECT and stable_cnt==STABLE_CYCLES-1.
//     - FAIL when oCycles==MAX_CYCLES-1 (the MAX_CYCLES-th RUN edge) and PASS
//       is not met. If both occur on the same edge, PASS wins.
//   PASS/FAIL: oDone=1 and oPass or oFail=1 (mutually exclusive). Counters frozen.
//     oCoreRstN goes 0 on entry if HALT_ON_DONE=1; otherwise it stays 1.
//   iRestart: honoured only in PASS/FAIL. Next edge: state=HOLD, with the same
//     clears as reset. Ignored in HOLD and RUN.
//   Output timing: all outputs registered; the verdict is visible the cycle
//     after the deciding edge.
//   X on iRd during HOLD is don't-care; iRd is not sampled in HOLD.
// TESTING
//   1 Reset 3 cycles, then release -> oCoreRstN low exactly 2 cycles after
//     release, then 1; all flags 0.
//   2 iRd=0 for 10 RUN cycles, then 32'hA constant -> oPass=1 and oDone=1 after
//     the 4th 0xA edge; oCycles=14; oRdChanges=1.
//   3 iRd toggles 0xA,0xA,0xA,0x5 repeatedly -> never passes; oFail=1 at
//     oCycles=100; oPass=0.
//   4 iRd=0xA only from RUN cycle 97 -> the 4th match coincides with cycle 100
//     -> PASS, not FAIL.
//   5 HALT_ON_DONE=1, scenario 2 -> oCoreRstN=0 on the PASS entry edge. Then
//     iRestart -> HOLD, counters 0, full rerun passes.
//   6 iRstN low mid-RUN (cycle 50) -> next edge: all outputs at reset values;
//     iRestart pulsed during RUN -> no effect.

Source files
------------

// File: rtl/cpu_run_monitor.sv
// Run controller and checker beside the CPU top: sequences the core reset, counts
// run cycles and declares PASS when rd holds EXPECT long enough, or FAIL on timeout.
module cpu_run_monitor #(
    parameter int unsigned     WIDTH         = 32,
    parameter int unsigned     RST_CYCLES    = 2,
    parameter int unsigned     MAX_CYCLES    = 100,
    parameter int unsigned     STABLE_CYCLES = 4,
    parameter logic [WIDTH-1:0] EXPECT       = WIDTH'(32'h0000_000A),
    parameter bit              HALT_ON_DONE  = 1'b0,
    parameter int unsigned     CNT_W         = 16
) (
    input  logic             iClk,
    input  logic             iRstN,
    input  logic [WIDTH-1:0] iRd,
    input  logic             iRestart,
    output logic             oCoreRstN,
    output logic             oDone,
    output logic             oPass,
    output logic             oFail,
    output logic [CNT_W-1:0] oCycles,
    output logic [CNT_W-1:0] oRdChanges
);

    localparam int unsigned HOLD_W = $clog2(RST_CYCLES + 1);
    localparam int unsigned STAB_W = $clog2(STABLE_CYCLES + 1);

    localparam logic [1:0] ST_HOLD = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_PASS = 2'd2;
    localparam logic [1:0] ST_FAIL = 2'd3;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CYC_LAST  = CNT_W'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic [1:0]        state_q,      state_d;
    logic [HOLD_W-1:0] hold_cnt_q,   hold_cnt_d;
    logic [STAB_W-1:0] stable_cnt_q, stable_cnt_d;
    logic [WIDTH-1:0]  prev_rd_q,    prev_rd_d;
    logic              core_rst_n_q, core_rst_n_d;
    logic              done_q,       done_d;
    logic              pass_q,       pass_d;
    logic              fail_q,       fail_d;
    logic [CNT_W-1:0]  cycles_q,     cycles_d;
    logic [CNT_W-1:0]  changes_q,    changes_d;
    logic              rd_match_c;

    assign rd_match_c = (iRd == EXPECT);

    // State and output registers; reset clears everything back to HOLD.
    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            state_q      <= ST_HOLD;
            hold_cnt_q   <= '0;
            stable_cnt_q <= '0;
            prev_rd_q    <= '0;
            core_rst_n_q <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_q       <= 1'b0;
            cycles_q     <= '0;
            changes_q    <= '0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            stable_cnt_q <= stable_cnt_d;
            prev_rd_q    <= prev_rd_d;
            core_rst_n_q <= core_rst_n_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            fail_q       <= fail_d;
            cycles_q     <= cycles_d;
            changes_q    <= changes_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        stable_cnt_d = stable_cnt_q;
        prev_rd_d    = prev_rd_q;
        core_rst_n_d = core_rst_n_q;
        done_d       = done_q;
        pass_d       = pass_q;
        fail_d       = fail_q;
        cycles_d     = cycles_q;
        changes_d    = changes_q;

        case (state_q)
            ST_HOLD: begin
                hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d      = ST_RUN;
                    core_rst_n_d = 1'b1;
                end
            end

            ST_RUN: begin
                if (cycles_q != CNT_MAX) begin
                    cycles_d = cycles_q + CNT_W'(1);
                end
                prev_rd_d = iRd;
                // cycles_q is zero only on the first RUN edge, where prev_rd is meaningless.
                if ((cycles_q != '0) && (iRd != prev_rd_q) && (changes_q != CNT_MAX)) begin
                    changes_d = changes_q + CNT_W'(1);
                end
                stable_cnt_d = rd_match_c ? (stable_cnt_q + STAB_W'(1)) : '0;

                if (rd_match_c && (stable_cnt_q == STAB_LAST)) begin
                    state_d = ST_PASS;
                    done_d  = 1'b1;
                    pass_d  = 1'b1;
                    if (HALT_ON_DONE) begin
                        core_rst_n_d = 1'b0;
                    end
                end else if (cycles_q == CYC_LAST) begin
                    state_d = ST_FAIL;
                    done_d  = 1'b1;
                    fail_d  = 1'b1;
                    if (HALT_ON_DONE) begin
                        core_rst_n_d = 1'b0;
                    end
                end
            end

            ST_PASS, ST_FAIL: begin
                if (iRestart) begin
                    state_d      = ST_HOLD;
                    hold_cnt_d   = '0;
                    stable_cnt_d = '0;
                    prev_rd_d    = '0;
                    core_rst_n_d = 1'b0;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    fail_d       = 1'b0;
                    cycles_d     = '0;
                    changes_d    = '0;
                end
            end

            default: begin
                state_d = ST_HOLD;
            end
        endcase
    end

    assign oCoreRstN  = core_rst_n_q;
    assign oDone      = done_q;
    assign oPass      = pass_q;
    assign oFail      = fail_q;
    assign oCycles    = cycles_q;
    assign oRdChanges = changes_q;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Scoreboard bench for cpu_run_monitor: two instances (HALT_ON_DONE 0 and 1) share
// stimulus; a sequence-level reference model predicts verdicts and snapshots.
module tb_cpu_run_monitor;

    localparam int unsigned MAXC = 100;
    localparam int unsigned STAB = 4;
    localparam logic [31:0] EXPV = 32'h0000_000A;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        restart;
    logic [31:0] rd;

    logic        core0, done0, pass0, fail0;
    logic [15:0] cyc0, chg0;
    logic        core1, done1, pass1, fail1;
    logic [15:0] cyc1, chg1;

    always #5 clk = ~clk;

    cpu_run_monitor #(.HALT_ON_DONE(1'b0)) dut0 (
        .iClk(clk), .iRstN(rst_n), .iRd(rd), .iRestart(restart),
        .oCoreRstN(core0), .oDone(done0), .oPass(pass0), .oFail(fail0),
        .oCycles(cyc0), .oRdChanges(chg0)
    );

    cpu_run_monitor #(.HALT_ON_DONE(1'b1)) dut1 (
        .iClk(clk), .iRstN(rst_n), .iRd(rd), .iRestart(restart),
        .oCoreRstN(core1), .oDone(done1), .oPass(pass1), .oFail(fail1),
        .oCycles(cyc1), .oRdChanges(chg1)
    );

    typedef struct {
        int          cyc;
        string       name;
        logic [36:0] exp;
    } snap_t;

    typedef struct {
        string       name;
        logic        pass;
        logic [15:0] cycles;
        logic [15:0] changes;
    } verdict_t;

    snap_t    sq[$];
    verdict_t vq0[$];
    verdict_t vq1[$];

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    bit fin_req = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs after the edge just taken; checked at the following negedge.
    task automatic push_snap(input string n, input logic c0, input logic c1, input logic d,
                             input logic p, input logic f, input int cy, input int ch);
        snap_t s;
        s.cyc  = cyc;
        s.name = n;
        s.exp  = {c0, c1, d, p, f, 16'(cy), 16'(ch)};
        sq.push_back(s);
    endtask

    // Reference: walk the RUN-cycle sequence; PASS once the trailing run of EXPV
    // reaches STAB, FAIL if MAXC cycles elapse first.
    function automatic void model(input logic [31:0] s[$], input int lim, output int kend,
                                  output bit done, output bit pass, output int chg);
        int run;
        run  = 0;
        chg  = 0;
        pass = 1'b0;
        done = 1'b0;
        kend = lim;
        for (int k = 1; k <= lim; k++) begin
            if (k > 1 && s[k-1] != s[k-2]) chg++;
            run = (s[k-1] == EXPV) ? run + 1 : 0;
            if (run >= int'(STAB)) begin
                kend = k;
                pass = 1'b1;
                done = 1'b1;
                return;
            end
        end
        done = (lim >= int'(MAXC));
    endfunction

    task automatic hold_phase(input string n);
        step();
        push_snap({n, "_hold1"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        step();
        push_snap({n, "_hold2"}, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic run_seq(input string n, input logic [31:0] s[$], input int lim,
                           input int rs_at);
        int       kend, chg;
        bit       dn, ps;
        verdict_t v;
        model(s, lim, kend, dn, ps, chg);
        if (dn) begin
            v.name = n; v.pass = ps; v.cycles = 16'(kend); v.changes = 16'(chg);
            vq0.push_back(v);
            vq1.push_back(v);
        end
        for (int k = 1; k <= kend; k++) begin
            rd      = s[k-1];
            restart = (k == rs_at);
            step();
        end
        restart = 1'b0;
        if (dn) begin
            push_snap({n, "_edge"}, 1'b1, 1'b0, 1'b1, ps, !ps, kend, chg);
            repeat (2) begin
                rd = $urandom;
                step();
            end
            push_snap({n, "_frozen"}, 1'b1, 1'b0, 1'b1, ps, !ps, kend, chg);
        end else begin
            push_snap({n, "_running"}, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, kend, chg);
        end
    endtask

    task automatic restart_run(input string n);
        rd      = $urandom;
        restart = 1'b1;
        step();
        restart = 1'b0;
        push_snap({n, "_clear"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        hold_phase(n);
    endtask

    function automatic logic [31:0] non_expect();
        logic [31:0] v;
        v = $urandom;
        if (v == EXPV) v = v ^ 32'h1;
        return v;
    endfunction

    // Stimulus
    initial begin
        logic [31:0] s[$];
        rst_n   = 1'b0;
        restart = 1'b0;
        rd      = $urandom;
        repeat (3) step();
        push_snap("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        rst_n = 1'b1;
        hold_phase("release");

        s.delete();
        for (int k = 0; k < int'(MAXC); k++) s.push_back(k < 10 ? 32'h0 : EXPV);
        run_seq("late_match", s, MAXC, -1);
        restart_run("rs1");

        s.delete();
        for (int k = 0; k < int'(MAXC); k++) s.push_back((k % 4 == 3) ? 32'h5 : EXPV);
        run_seq("toggle_timeout", s, MAXC, -1);
        restart_run("rs2");

        s.delete();
        for (int k = 0; k < int'(MAXC); k++) s.push_back(k < 96 ? non_expect() : EXPV);
        run_seq("pass_at_limit", s, MAXC, -1);
        restart_run("rs3");

        s.delete();
        for (int k = 0; k < int'(MAXC); k++) s.push_back(32'h5);
        run_seq("mid_run", s, 49, 20);
        rst_n = 1'b0;
        rd    = $urandom;
        step();
        push_snap("mid_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        repeat (2) step();
        rst_n = 1'b1;
        hold_phase("rerelease");

        for (int r = 0; r < 8; r++) begin
            s.delete();
            for (int k = 0; k < int'(MAXC); k++)
                s.push_back(($urandom_range(0, 4) != 0) ? EXPV : 32'($urandom_range(0, 15)));
            run_seq($sformatf("rand%0d", r), s, MAXC, int'($urandom_range(1, 100)));
            restart_run($sformatf("rrs%0d", r));
        end

        step();
        fin_req = 1'b1;
    end

    // Monitor / scoreboard
    initial begin
        snap_t       cur;
        verdict_t    v;
        logic [36:0] act;
        logic [33:0] vexp, vact;
        logic        d0_prev = 1'b0;
        logic        d1_prev = 1'b0;
        forever begin
            @(negedge clk);
            while (sq.size() > 0 && sq[0].cyc <= cyc) begin
                cur = sq.pop_front();
                act = {core0, core1, done0, pass0, fail0, cyc0, chg0};
                checks++;
                if (act !== cur.exp || cur.cyc != cyc) begin
                    errors++;
                    $display("FAIL %s dut0 @%0d: got %h expected %h", cur.name, cyc, act, cur.exp);
                end
                act = {core0, core1, done1, pass1, fail1, cyc1, chg1};
                checks++;
                if (act !== cur.exp || cur.cyc != cyc) begin
                    errors++;
                    $display("FAIL %s dut1 @%0d: got %h expected %h", cur.name, cyc, act, cur.exp);
                end
            end
            if (done0 === 1'b1 && d0_prev !== 1'b1) begin
                checks++;
                vact = {pass0, fail0, cyc0, chg0};
                if (vq0.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_verdict dut0 @%0d: got %h expected none", cyc, vact);
                end else begin
                    v    = vq0.pop_front();
                    vexp = {v.pass, !v.pass, v.cycles, v.changes};
                    if (vact !== vexp) begin
                        errors++;
                        $display("FAIL %s verdict dut0: got %h expected %h", v.name, vact, vexp);
                    end
                end
            end
            if (done1 === 1'b1 && d1_prev !== 1'b1) begin
                checks++;
                vact = {pass1, fail1, cyc1, chg1};
                if (vq1.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_verdict dut1 @%0d: got %h expected none", cyc, vact);
                end else begin
                    v    = vq1.pop_front();
                    vexp = {v.pass, !v.pass, v.cycles, v.changes};
                    if (vact !== vexp) begin
                        errors++;
                        $display("FAIL %s verdict dut1: got %h expected %h", v.name, vact, vexp);
                    end
                end
            end
            d0_prev = done0;
            d1_prev = done1;
            if (fin_req) begin
                checks++;
                if (vq0.size() + vq1.size() + sq.size() != 0) begin
                    errors++;
                    $display("FAIL leftover_expectations: got %0d pending expected 0",
                             vq0.size() + vq1.size() + sq.size());
                end
                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                $finish;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
